// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared op/state encodings for the iterative multiply/divide unit
// Rev 1.0
// ============================================================================
package muldiv_pkg;

  // RISC-V M-extension funct3 encoding
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// muldiv_div_iter : radix-2 restoring divider on unsigned magnitudes
// Rev 1.0
// ============================================================================
module muldiv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int                 c_cnt_w = $clog2(XLEN + 1);
  localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(XLEN);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    dvs_q, dvs_d;
  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_diff;
  logic [XLEN-1:0]    w_quo_nxt;
  logic [XLEN-1:0]    w_rem_nxt;

  // Trial subtract; a borrow in the top bit means restore the shifted remainder.
  assign w_shift   = {rem_q, quo_q[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, dvs_q};
  assign w_quo_nxt = {quo_q[XLEN-2:0], ~w_diff[XLEN]};
  assign w_rem_nxt = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];

  always_comb begin
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start_i) begin
      cnt_d = c_iters;
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - c_one;
      quo_d = w_quo_nxt;
      rem_d = w_rem_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  // Final quotient/remainder are presented during the last iteration cycle.
  assign busy_o      = (cnt_q != '0);
  assign done_o      = (cnt_q == c_one);
  assign quotient_o  = w_quo_nxt;
  assign remainder_o = w_rem_nxt;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit_param.sv
`default_nettype none
// ============================================================================
// muldiv_unit_param : XLEN-parametrised RV32IM multiply/divide execute unit
// Rev 1.0
// ============================================================================
module muldiv_unit_param
  import muldiv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit DIV_EARLY_OUT = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_ra_i,
  input  logic [XLEN-1:0] operand_rb_i,
  output logic            ready_o,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   ra_q, ra_d;
  logic [XLEN-1:0]   rb_q, rb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_accept;
  logic              w_in_signed;
  logic              w_in_special;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [XLEN-1:0]   w_ra_mag;
  logic [XLEN-1:0]   w_rb_mag;
  logic [XLEN-1:0]   w_quo_mag;
  logic [XLEN-1:0]   w_rem_mag;
  logic              w_a_sx;
  logic              w_b_sx;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

  // Applies operand signs to the magnitudes, then forces the architected
  // divide-by-zero and signed-overflow values.
  function automatic logic [XLEN-1:0] div_fixup(input logic [2:0]      op,
                                                input logic [XLEN-1:0] ra,
                                                input logic [XLEN-1:0] rb,
                                                input logic [XLEN-1:0] quo,
                                                input logic [XLEN-1:0] rem);
    logic            sgn;
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    sgn = (op == OP_DIV) || (op == OP_REM);
    q   = (sgn && (ra[XLEN-1] ^ rb[XLEN-1])) ? -quo : quo;
    r   = (sgn && ra[XLEN-1]) ? -rem : rem;
    if (rb == '0) begin
      q = '1;
      r = ra;
    end else if (sgn && (ra == c_int_min) && (rb == '1)) begin
      q = ra;
      r = '0;
    end
    return op[1] ? r : q;
  endfunction

  assign w_accept     = valid_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_in_signed  = (op_i == OP_DIV) || (op_i == OP_REM);
  assign w_ra_mag     = (w_in_signed && operand_ra_i[XLEN-1]) ? -operand_ra_i : operand_ra_i;
  assign w_rb_mag     = (w_in_signed && operand_rb_i[XLEN-1]) ? -operand_rb_i : operand_rb_i;
  assign w_in_special = (operand_rb_i == '0) ||
                        (w_in_signed && (operand_ra_i == c_int_min) && (operand_rb_i == '1));
  assign w_div_start  = w_accept && is_div_op(op_i) && !(DIV_EARLY_OUT && w_in_special);

  // The low 2*XLEN bits of the sign-extended product equal those of the
  // (XLEN+1)x(XLEN+1) signed product, so no wider result is needed.
  assign w_a_sx    = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && ra_q[XLEN-1];
  assign w_b_sx    = (op_q == OP_MULH) && rb_q[XLEN-1];
  assign w_prod    = {{XLEN{w_a_sx}}, ra_q} * {{XLEN{w_b_sx}}, rb_q};
  assign w_mul_res = (op_q == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  muldiv_div_iter #(
    .XLEN (XLEN)
  ) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (w_div_start),
    .dividend_i  (w_ra_mag),
    .divisor_i   (w_rb_mag),
    .busy_o      (w_div_busy),
    .done_o      (w_div_done),
    .quotient_o  (w_quo_mag),
    .remainder_o (w_rem_mag)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    result_d = result_q;
    case (state_q)
      ST_MUL: begin
        result_d = w_mul_res;
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        if (w_div_done) begin
          result_d = div_fixup(op_q, ra_q, rb_q, w_quo_mag, w_rem_mag);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = state_q;
    endcase
    if (w_accept) begin
      op_d = op_i;
      ra_d = operand_ra_i;
      rb_d = operand_rb_i;
      if (!is_div_op(op_i)) begin
        state_d = ST_MUL;
      end else if (w_div_start) begin
        state_d = ST_DIV;
      end else begin
        result_d = div_fixup(op_i, operand_ra_i, operand_rb_i, '0, '0);
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == ST_DONE);
  assign stall_o  = (state_q == ST_MUL) || w_div_busy;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit_param.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit_param : directed bench for XLEN=32, XLEN=32 early-out, XLEN=16
// Rev 1.0
// ============================================================================
module tb_muldiv_unit_param;
  import muldiv_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  valid = 3'b000;
  logic [2:0]  op = 3'd0;
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic        rdy0, stl0, rdy1, stl1, rdy2, stl2;
  logic [31:0] res0, res1;
  logic [15:0] res2;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  muldiv_unit_param #(.XLEN(32), .DIV_EARLY_OUT(1'b0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[0]), .op_i(op),
    .operand_ra_i(ra), .operand_rb_i(rb),
    .ready_o(rdy0), .stall_o(stl0), .result_o(res0));

  muldiv_unit_param #(.XLEN(32), .DIV_EARLY_OUT(1'b1)) u_dut32_eo (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[1]), .op_i(op),
    .operand_ra_i(ra), .operand_rb_i(rb),
    .ready_o(rdy1), .stall_o(stl1), .result_o(res1));

  muldiv_unit_param #(.XLEN(16), .DIV_EARLY_OUT(1'b0)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[2]), .op_i(op),
    .operand_ra_i(ra[15:0]), .operand_rb_i(rb[15:0]),
    .ready_o(rdy2), .stall_o(stl2), .result_o(res2));

  function automatic logic get_rdy(input int d);
    if (d == 0) return rdy0;
    if (d == 1) return rdy1;
    return rdy2;
  endfunction

  function automatic logic get_stl(input int d);
    if (d == 0) return stl0;
    if (d == 1) return stl1;
    return stl2;
  endfunction

  function automatic logic [31:0] get_res(input int d);
    if (d == 0) return res0;
    if (d == 1) return res1;
    return {16'h0000, res2};
  endfunction

  function automatic int div_lat(input int d);
    return (d == 2) ? 17 : 33;
  endfunction

  // Issues one op and observes a fixed window; comparisons happen in the callers.
  task automatic run_op(input int d, input vec_t v, input int win,
                        output int first_k, output logic [31:0] got,
                        output int n_rdy, output int n_stall);
    first_k = 0; got = '0; n_rdy = 0; n_stall = 0;
    @(negedge clk);
    op = v.op; ra = v.a; rb = v.b; valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = 1'b0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      if (get_rdy(d)) begin
        n_rdy++;
        if (first_k == 0) begin first_k = k; got = get_res(d); end
      end
      if (get_stl(d)) n_stall++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks += 3;
      if (get_rdy(d) !== 1'b0) begin n_errors++; $display("FAIL reset ready dut%0d: got %b want 0", d, get_rdy(d)); end
      if (get_stl(d) !== 1'b0) begin n_errors++; $display("FAIL reset stall dut%0d: got %b want 0", d, get_stl(d)); end
      if (get_res(d) !== 32'h0) begin n_errors++; $display("FAIL reset result dut%0d: got %h want 0", d, get_res(d)); end
    end
    rst = 1'b0;
  endtask

  task automatic test_mul(input int d);
    vec_t v[4];
    int fk, nr, ns;
    logic [31:0] got;
    if (d == 2) begin
      v[0] = '{OP_MULH,   32'h8000, 32'h8000, 32'h4000};
      v[1] = '{OP_MUL,    32'h0107, 32'h0010, 32'h1070};
      v[2] = '{OP_MULHU,  32'hFFFF, 32'hFFFF, 32'hFFFE};
      v[3] = '{OP_MULHSU, 32'hFFFF, 32'h0002, 32'hFFFF};
    end else begin
      v[0] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
      v[1] = '{OP_MUL,    32'h00000007, 32'h00000006, 32'h0000002A};
      v[2] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      v[3] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    end
    for (int i = 0; i < 4; i++) begin
      run_op(d, v[i], 5, fk, got, nr, ns);
      n_checks += 4;
      if (got !== v[i].e) begin n_errors++; $display("FAIL mul[%0d] dut%0d result: got %h want %h", i, d, got, v[i].e); end
      if (fk != 2) begin n_errors++; $display("FAIL mul[%0d] dut%0d latency: got %0d want 2", i, d, fk); end
      if (nr != 1) begin n_errors++; $display("FAIL mul[%0d] dut%0d ready pulses: got %0d want 1", i, d, nr); end
      if (ns != 1) begin n_errors++; $display("FAIL mul[%0d] dut%0d stall cycles: got %0d want 1", i, d, ns); end
    end
  endtask

  task automatic test_div(input int d);
    vec_t v[6];
    int fk, nr, ns, lat;
    logic [31:0] got, want, mask;
    lat  = div_lat(d);
    mask = (d == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
    v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
    v[1] = '{OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
    v[2] = '{OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E};
    v[3] = '{OP_REMU, 32'h00000064, 32'h00000007, 32'h00000002};
    v[4] = '{OP_DIV,  32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA};
    v[5] = '{OP_REM,  32'h00000014, 32'hFFFFFFFD, 32'h00000002};
    for (int i = 0; i < 6; i++) begin
      want = v[i].e & mask;
      run_op(d, v[i], lat + 3, fk, got, nr, ns);
      n_checks += 4;
      if (got !== want) begin n_errors++; $display("FAIL div[%0d] dut%0d result: got %h want %h", i, d, got, want); end
      if (fk != lat) begin n_errors++; $display("FAIL div[%0d] dut%0d latency: got %0d want %0d", i, d, fk, lat); end
      if (nr != 1) begin n_errors++; $display("FAIL div[%0d] dut%0d ready pulses: got %0d want 1", i, d, nr); end
      if (ns != lat - 1) begin n_errors++; $display("FAIL div[%0d] dut%0d stall cycles: got %0d want %0d", i, d, ns, lat - 1); end
    end
  endtask

  task automatic test_special(input int d);
    vec_t v[6];
    int fk, nr, ns, lat;
    logic [31:0] got, want, mask, mn;
    lat  = (d == 1) ? 1 : div_lat(d);
    mask = (d == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
    mn   = (d == 2) ? 32'h00008000 : 32'h80000000;
    v[0] = '{OP_DIVU, 32'h00000055, 32'h00000000, 32'hFFFFFFFF};
    v[1] = '{OP_REMU, 32'h00001234, 32'h00000000, 32'h00001234};
    v[2] = '{OP_DIV,  mn,           32'hFFFFFFFF, mn};
    v[3] = '{OP_REM,  mn,           32'hFFFFFFFF, 32'h00000000};
    v[4] = '{OP_DIV,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF};
    v[5] = '{OP_REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB};
    for (int i = 0; i < 6; i++) begin
      want = v[i].e & mask;
      run_op(d, v[i], lat + 3, fk, got, nr, ns);
      n_checks += 4;
      if (got !== want) begin n_errors++; $display("FAIL special[%0d] dut%0d result: got %h want %h", i, d, got, want); end
      if (fk != lat) begin n_errors++; $display("FAIL special[%0d] dut%0d latency: got %0d want %0d", i, d, fk, lat); end
      if (nr != 1) begin n_errors++; $display("FAIL special[%0d] dut%0d ready pulses: got %0d want 1", i, d, nr); end
      if (ns != lat - 1) begin n_errors++; $display("FAIL special[%0d] dut%0d stall cycles: got %0d want %0d", i, d, ns, lat - 1); end
    end
  endtask

  // Non-special ops on the early-out instance keep their normal latency.
  task automatic test_early_out();
    vec_t v[3];
    int   lat_v[3];
    int   fk, nr, ns;
    logic [31:0] got;
    v[0] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD}; lat_v[0] = 33;
    v[1] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}; lat_v[1] = 33;
    v[2] = '{OP_MUL,  32'h00000007, 32'h00000006, 32'h0000002A}; lat_v[2] = 2;
    for (int i = 0; i < 3; i++) begin
      run_op(1, v[i], lat_v[i] + 3, fk, got, nr, ns);
      n_checks += 3;
      if (got !== v[i].e) begin n_errors++; $display("FAIL early_out[%0d] result: got %h want %h", i, got, v[i].e); end
      if (fk != lat_v[i]) begin n_errors++; $display("FAIL early_out[%0d] latency: got %0d want %0d", i, fk, lat_v[i]); end
      if (ns != lat_v[i] - 1) begin n_errors++; $display("FAIL early_out[%0d] stall cycles: got %0d want %0d", i, ns, lat_v[i] - 1); end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int          lat, fk1, fk2, nr;
    logic [31:0] g1, g2, want1;
    logic        s_mid;
    lat   = div_lat(d);
    want1 = (d == 2) ? 32'h0000FFFD : 32'hFFFFFFFD;
    fk1 = 0; fk2 = 0; nr = 0; g1 = '0; g2 = '0; s_mid = 1'b0;
    @(negedge clk);
    op = OP_DIV; ra = 32'hFFFFFFF9; rb = 32'h2; valid[d] = 1'b1;
    @(posedge clk); #1;
    op = OP_MUL; ra = 32'h7; rb = 32'h6;
    for (int k = 1; k <= lat + 5; k++) begin
      @(negedge clk);
      if (get_rdy(d)) begin
        nr++;
        if (fk1 == 0) begin fk1 = k; g1 = get_res(d); end
        else if (fk2 == 0) begin fk2 = k; g2 = get_res(d); end
      end
      if (k == lat + 1) begin s_mid = get_stl(d); valid[d] = 1'b0; end
    end
    n_checks += 6;
    if (fk1 != lat) begin n_errors++; $display("FAIL b2b dut%0d div latency: got %0d want %0d", d, fk1, lat); end
    if (g1 !== want1) begin n_errors++; $display("FAIL b2b dut%0d div result: got %h want %h", d, g1, want1); end
    if (fk2 != lat + 2) begin n_errors++; $display("FAIL b2b dut%0d mul ready cycle: got %0d want %0d", d, fk2, lat + 2); end
    if (g2 !== 32'h2A) begin n_errors++; $display("FAIL b2b dut%0d mul result: got %h want 0000002a", d, g2); end
    if (s_mid !== 1'b1) begin n_errors++; $display("FAIL b2b dut%0d mul stall: got %b want 1", d, s_mid); end
    if (nr != 2) begin n_errors++; $display("FAIL b2b dut%0d ready pulses: got %0d want 2", d, nr); end
  endtask

  task automatic test_reset_mid_div(input int d);
    int nr;
    @(negedge clk);
    op = OP_DIV; ra = 32'hFFFFFFF9; rb = 32'h2; valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (get_stl(d) !== 1'b1) begin n_errors++; $display("FAIL rst_mid dut%0d stall before reset: got %b want 1", d, get_stl(d)); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks += 3;
    if (get_stl(d) !== 1'b0) begin n_errors++; $display("FAIL rst_mid dut%0d stall: got %b want 0", d, get_stl(d)); end
    if (get_rdy(d) !== 1'b0) begin n_errors++; $display("FAIL rst_mid dut%0d ready: got %b want 0", d, get_rdy(d)); end
    if (get_res(d) !== 32'h0) begin n_errors++; $display("FAIL rst_mid dut%0d result: got %h want 0", d, get_res(d)); end
    nr = 0;
    repeat (40) begin
      @(negedge clk);
      if (get_rdy(d)) nr++;
    end
    n_checks++;
    if (nr != 0) begin n_errors++; $display("FAIL rst_mid dut%0d late ready pulses: got %0d want 0", d, nr); end
  endtask

  initial begin
    test_reset();
    test_mul(0);
    test_mul(2);
    test_div(0);
    test_div(2);
    test_special(0);
    test_special(1);
    test_special(2);
    test_early_out();
    test_back_to_back(0);
    test_reset_mid_div(0);
    test_back_to_back(2);
    test_reset_mid_div(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
